envelope_follower: RTL
======================

Name: envelope_follower

Overview:
- Produces the per-band modulator envelopes that the mixer consumes as envelope_channels.
- Input is the 8 bandpassed mic (modulator) channels from the filterbank, one frame per valid_in.
- Each band is full-wave rectified and smoothed by a one-pole attack/release low-pass.
- Bands are processed serially, one per clock, through one shared datapath. A single valid_out pulse then presents all 8 envelopes to the mixer.

Parameters:
- NUM_CHANNELS, 8, number of bands; counter width is $clog2(NUM_CHANNELS).
- WIDTH, 32, signed sample width in; envelope width out.
- ATTACK_SHIFT, 4, smoothing shift when the rectified input is above the envelope (0 = instant attack).
- RELEASE_SHIFT, 10, smoothing shift when the rectified input is at or below the envelope; must be >= 1.

Ports:
- clk_in  input  1  system audio clock (98.3 MHz domain).
- rst_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  single-cycle strobe; band_in holds a new frame.
- band_in  input  signed [WIDTH-1:0] x [NUM_CHANNELS]  bandpassed modulator samples.
- envelope_out  output  signed [WIDTH-1:0] x [NUM_CHANNELS]  envelopes; always >= 0.
- valid_out  output  1  single-cycle strobe; envelope_out has been updated.
- overrun_out  output  1  sticky; set when a frame was dropped.

Behaviour:
- Reset (async assert, any state): state=IDLE, ch=0, all env_state=0, envelope_out=0, valid_out=0, overrun_out=0. Input capture registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - valid_in=1 at edge E0: capture all band_in into frame regs, ch<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (edges E1..E8): update env_state[ch] from frame[ch], then ch<=ch+1. At the update of ch=NUM_CHANNELS-1, go to DONE and set ch<=0.
- DONE (edge E9): envelope_out<=env_state (all channels at once), valid_out<=1 for exactly one cycle, go to IDLE.
- Latency: valid_out is high in the cycle after E9, i.e. NUM_CHANNELS+1 edges after the capturing edge.
- valid_out is deasserted on the edge following its assertion.
- envelope_out holds its value between frames.
- valid_in while in RUN or DONE: the frame is dropped, overrun_out<=1. It stays set until reset; there is no other side effect.
- A new valid_in in the same cycle that valid_out is high is accepted normally (the state is already IDLE).
- Update arithmetic (per channel):
  - r = |x|; x = most-negative value saturates to 2^(WIDTH-1)-1.
  - d = r - env, computed WIDTH+1 bits signed.
  - k = ATTACK_SHIFT if d>0, else RELEASE_SHIFT.
  - env_next = env + (d >>> k), arithmetic shift (floor).
- Width/sign guarantees:
  - env_next stays in [0, 2^(WIDTH-1)-1]; no saturation logic is needed beyond the rectifier.
  - Decay converges exactly to r, because the floor yields -1 for small negative d.
- env_state persists across frames; it is the filter memory.

Decomposition:
- Shared constants package gets NUM_BANDS=8, ENV_WIDTH=32, ENV_ATTACK_SHIFT, ENV_RELEASE_SHIFT. It also gets a state typedef {IDLE, RUN, DONE}.
- One combinational sub-module, env_update: inputs x, env; parameters ATTACK_SHIFT, RELEASE_SHIFT; output env_next. It holds the rectify, saturate, compare and shift-add logic and is unit-tested standalone.

Test Plan:
- ATTACK_SHIFT=4, env=0, band_in[0]=0x00001000 for two frames -> envelope_out[0]=0x100, then 0x1F0. Repeat with band_in[0]=-0x1000 -> identical values. valid_out is high exactly 9 cycles after each valid_in edge, for one cycle.
- ATTACK_SHIFT=0, RELEASE_SHIFT=10: frame x=0x00010000 -> env=0x00010000. Next frame x=0 -> env=0x0000FFC0. Feed x=0 repeatedly -> env reaches exactly 0 and never goes negative.
- band_in[3]=0x80000000 with ATTACK_SHIFT=0 -> envelope_out[3]=0x7FFFFFFF. Other channels with x=0 remain 0, which checks channel isolation and indexing.
- valid_in at E0 and again 3 cycles later -> the second frame is ignored, overrun_out=1 and stays set. Exactly one valid_out pulse occurs, and its values come from the first frame only.
- rst_in asserted asynchronously mid-RUN (ch=4) -> immediately all outputs=0 and state=IDLE. The next frame yields results computed from env=0, e.g. 0x100 for x=0x1000 with ATTACK_SHIFT=4.
- Back-to-back frames with valid_in in the cycle valid_out is high -> accepted, with no overrun and a second valid_out 9 cycles later.

Source files
------------

// File: rtl/envelope_follower_pkg.sv
// Shared constants and types for the modulator envelope follower.
// Exports the default band count, the sample/envelope width and the default
// attack/release shifts, plus the sequencer state type.
package envelope_follower_pkg;

  localparam int NUM_BANDS         = 8;
  localparam int ENV_WIDTH         = 32;
  localparam int ENV_ATTACK_SHIFT  = 4;
  localparam int ENV_RELEASE_SHIFT = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/envelope_follower_if.sv
// Frame bus between the filterbank/mixer and the envelope follower.
//   valid_in     : single-cycle strobe, band_in holds a new frame
//   band_in      : bandpassed modulator samples, one per band
//   envelope_out : per-band envelopes (never negative)
//   valid_out    : single-cycle strobe, envelope_out was just updated
//   overrun_out  : sticky flag, a frame arrived while busy and was dropped
// master = producer/consumer side, slave = envelope follower.
interface envelope_follower_if
  import envelope_follower_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_BANDS,
  parameter int WIDTH        = ENV_WIDTH
);

  logic                    valid_in;
  logic signed [WIDTH-1:0] band_in      [NUM_CHANNELS];
  logic signed [WIDTH-1:0] envelope_out [NUM_CHANNELS];
  logic                    valid_out;
  logic                    overrun_out;

  modport master (
    output valid_in,
    output band_in,
    input  envelope_out,
    input  valid_out,
    input  overrun_out
  );

  modport slave (
    input  valid_in,
    input  band_in,
    output envelope_out,
    output valid_out,
    output overrun_out
  );

endinterface

// File: rtl/envelope_follower_env_update.sv
// One-pole attack/release envelope step for a single band (combinational).
//   x        : signed input sample
//   env      : current envelope (>= 0)
//   env_next : env + ((|x| - env) >>> k), k = ATTACK_SHIFT when rising,
//              RELEASE_SHIFT otherwise
// The rectifier saturates the most-negative input so |x| fits in WIDTH bits.
module env_update
  import envelope_follower_pkg::*;
#(
  parameter int WIDTH         = ENV_WIDTH,
  parameter int ATTACK_SHIFT  = ENV_ATTACK_SHIFT,
  parameter int RELEASE_SHIFT = ENV_RELEASE_SHIFT
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] env,
  output logic signed [WIDTH-1:0] env_next
);

  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic signed [WIDTH-1:0] rect;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH:0]   step;
  logic signed [WIDTH:0]   sum;
  logic                    sum_msb_unused;

  always_comb begin
    if (x == MOST_NEG) begin
      rect = MOST_POS;
    end else if (x[WIDTH-1]) begin
      rect = -x;
    end else begin
      rect = x;
    end

    diff = {rect[WIDTH-1], rect} - {env[WIDTH-1], env};

    // Arithmetic shift floors, so a small negative diff still yields -1 and
    // the release phase settles exactly on the rectified input.
    if (diff > 0) begin
      step = diff >>> ATTACK_SHIFT;
    end else begin
      step = diff >>> RELEASE_SHIFT;
    end

    sum = {env[WIDTH-1], env} + step;
  end

  // The result always lies between env and |x|, so it fits in WIDTH bits.
  assign env_next       = sum[WIDTH-1:0];
  assign sum_msb_unused = sum[WIDTH];

endmodule

// File: rtl/envelope_follower.sv
// Per-band modulator envelope follower feeding the mixer.
// A frame captured on valid_in is processed one band per clock through a
// single shared env_update datapath; after the last band all envelopes are
// published together with a one-cycle valid_out.
//   clk_in  : audio system clock
//   rst_in  : asynchronous, active-high reset
//   bus     : envelope_follower_if slave (valid_in, band_in, envelope_out,
//             valid_out, overrun_out)
module envelope_follower
  import envelope_follower_pkg::*;
#(
  parameter int NUM_CHANNELS  = NUM_BANDS,
  parameter int WIDTH         = ENV_WIDTH,
  parameter int ATTACK_SHIFT  = ENV_ATTACK_SHIFT,
  parameter int RELEASE_SHIFT = ENV_RELEASE_SHIFT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  envelope_follower_if.slave bus
);

  localparam int              CW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CW-1:0]   LAST = CW'(NUM_CHANNELS - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    capture, update, publish;

  logic signed [WIDTH-1:0] frame_q   [NUM_CHANNELS];
  logic signed [WIDTH-1:0] env_q     [NUM_CHANNELS];
  logic signed [WIDTH-1:0] env_out_q [NUM_CHANNELS];
  logic signed [WIDTH-1:0] env_next;

  env_update #(
    .WIDTH         (WIDTH),
    .ATTACK_SHIFT  (ATTACK_SHIFT),
    .RELEASE_SHIFT (RELEASE_SHIFT)
  ) u_env_update (
    .x        (frame_q[ch_q]),
    .env      (env_q[ch_q]),
    .env_next (env_next)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    capture   = 1'b0;
    update    = 1'b0;
    publish   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          capture = 1'b1;
          ch_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        update = 1'b1;
        if (ch_q == LAST) begin
          ch_d    = '0;
          state_d = DONE;
        end else begin
          ch_d = ch_q + CW'(1);
        end
        if (bus.valid_in) overrun_d = 1'b1;
      end
      DONE: begin
        publish = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
        if (bus.valid_in) overrun_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ch_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        frame_q[i]   <= '0;
        env_q[i]     <= '0;
        env_out_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          frame_q[i] <= bus.band_in[i];
        end
      end
      if (update) begin
        env_q[ch_q] <= env_next;
      end
      if (publish) begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          env_out_q[i] <= env_q[i];
        end
      end
    end
  end

  assign bus.envelope_out = env_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.overrun_out  = overrun_q;

endmodule
